// File: rtl/sdp_rdma_lat_credit_fifo_if.sv
// Handshake bundle for the SDP read-DMA latency FIFO: request pass-through,
// dmaif response beats and the egress read port.
interface sdp_rdma_lat_credit_fifo_if #(
  parameter int unsigned DATA_W = 514,
  parameter int unsigned REQ_W  = 79,
  parameter int unsigned LEN_W  = 4
);
  logic              in_req_vld;
  logic              in_req_rdy;
  logic [REQ_W-1:0]  in_req_pd;
  logic [LEN_W-1:0]  in_req_len;
  logic              out_req_vld;
  logic              out_req_rdy;
  logic [REQ_W-1:0]  out_req_pd;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [DATA_W-1:0] rsp_pd;
  logic              rd_vld;
  logic              rd_rdy;
  logic [DATA_W-1:0] rd_pd;

  // slave: the FIFO controller's view
  modport slave (
    input  in_req_vld, in_req_pd, in_req_len, out_req_rdy, rsp_vld, rsp_pd, rd_rdy,
    output in_req_rdy, out_req_vld, out_req_pd, rsp_rdy, rd_vld, rd_pd
  );

  modport master (
    output in_req_vld, in_req_pd, in_req_len, out_req_rdy, rsp_vld, rsp_pd, rd_rdy,
    input  in_req_rdy, out_req_vld, out_req_pd, rsp_rdy, rd_vld, rd_pd
  );
endinterface

// File: rtl/sdp_rdma_lat_credit_fifo.sv
// Latency FIFO plus credit gate for SDP read DMAs: a request is only released
// when every beat it will return already owns a FIFO slot.
module sdp_rdma_lat_credit_fifo #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = 514,
  parameter int unsigned REQ_W  = 79,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                       nvdla_core_clk,
  input  logic                       nvdla_core_rst,
  input  logic                       op_load,
  input  logic                       perf_en,
  sdp_rdma_lat_credit_fifo_if.slave  bus,
  output logic                       cdt_pop,
  output logic [CNT_W-1:0]           credits,
  output logic [31:0]                stall_cnt,
  output logic                       ovf_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Wide enough that len+1 never wraps, so oversized requests simply never fit
  localparam int unsigned NW = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;

  logic [CNT_W-1:0]  credits_q, credits_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              cdt_pop_q, cdt_pop_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic              ovf_err_q, ovf_err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [NW-1:0]     need;
  logic              credit_ok;
  logic              grant;
  logic              pop;
  logic              full;
  logic              wr_en;
  logic              drop;

  assign need      = NW'(bus.in_req_len) + NW'(1);
  assign credit_ok = NW'(credits_q) >= need;

  assign bus.out_req_vld = bus.in_req_vld & credit_ok;
  assign bus.in_req_rdy  = bus.out_req_rdy & credit_ok;
  assign bus.out_req_pd  = bus.in_req_pd;
  assign bus.rsp_rdy     = 1'b1;

  assign grant = bus.in_req_vld & bus.in_req_rdy;
  assign full  = occ_q == CNT_W'(DEPTH);
  assign pop   = bus.rd_vld & bus.rd_rdy;
  // A pop on a full FIFO frees the head slot before the incoming beat lands
  assign wr_en = bus.rsp_vld & (~full | pop);
  assign drop  = bus.rsp_vld & full & ~pop;

  assign bus.rd_vld = occ_q != '0;
  assign bus.rd_pd  = mem_q[rd_ptr_q];

  always_comb begin
    credits_d   = credits_q + CNT_W'(pop);
    if (grant) begin
      credits_d = credits_d - need[CNT_W-1:0];
    end
    occ_d       = occ_q + CNT_W'(wr_en) - CNT_W'(pop);
    wr_ptr_d    = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cdt_pop_d   = pop;

    stall_cnt_d = stall_cnt_q;
    if (op_load) begin
      stall_cnt_d = '0;
    end else if (perf_en && bus.in_req_vld && !credit_ok && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end

    ovf_err_d   = ovf_err_q;
    if (drop) begin
      ovf_err_d = 1'b1;
    end else if (op_load) begin
      ovf_err_d = 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      credits_q   <= CNT_W'(DEPTH);
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cdt_pop_q   <= 1'b0;
      stall_cnt_q <= '0;
      ovf_err_q   <= 1'b0;
    end else begin
      credits_q   <= credits_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cdt_pop_q   <= cdt_pop_d;
      stall_cnt_q <= stall_cnt_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge nvdla_core_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.rsp_pd;
    end
  end

  assign cdt_pop   = cdt_pop_q;
  assign credits   = credits_q;
  assign stall_cnt = stall_cnt_q;
  assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_sdp_rdma_lat_credit_fifo.sv
// Bench for sdp_rdma_lat_credit_fifo: directed steps plus a random phase, all
// checked against a queue-and-integer model of credits and buffered beats.
module tb_sdp_rdma_lat_credit_fifo;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REQ_W  = 16;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             op_load;
  logic             perf_en;
  logic             cdt_pop;
  logic [CNT_W-1:0] credits;
  logic [31:0]      stall_cnt;
  logic             ovf_err;

  sdp_rdma_lat_credit_fifo_if #(.DATA_W(DATA_W), .REQ_W(REQ_W), .LEN_W(LEN_W)) bus ();

  sdp_rdma_lat_credit_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .REQ_W (REQ_W),
    .LEN_W (LEN_W)
  ) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .op_load       (op_load),
    .perf_en       (perf_en),
    .bus           (bus.slave),
    .cdt_pop       (cdt_pop),
    .credits       (credits),
    .stall_cnt     (stall_cnt),
    .ovf_err       (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: free credits, buffered beats, sticky/perf state
  bit                m_init = 1'b0;
  int                m_cred;
  logic [DATA_W-1:0] m_q[$];
  bit                m_ovf;
  logic [31:0]       m_stall;
  bit                m_cdt;
  int                m_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cred  = DEPTH;
    m_q     = {};
    m_ovf   = 1'b0;
    m_stall = '0;
    m_cdt   = 1'b0;
    m_out   = 0;
    m_init  = 1'b1;
  endtask

  // Check the present cycle against the model, clock once, advance the model
  task automatic cycle();
    int need;
    bit ok, pop, grant, drop;
    #1;
    need  = int'(bus.in_req_len) + 1;
    ok    = m_cred >= need;
    pop   = (m_q.size() != 0) && bus.rd_rdy;
    grant = bus.in_req_vld && bus.out_req_rdy && ok;
    drop  = bus.rsp_vld && ((m_q.size() - int'(pop)) >= DEPTH);
    if (m_init && !rst) begin
      chk("in_req_rdy", 64'(bus.in_req_rdy), 64'(bus.out_req_rdy && ok));
      chk("out_req_vld", 64'(bus.out_req_vld), 64'(bus.in_req_vld && ok));
      chk("out_req_pd", 64'(bus.out_req_pd), 64'(bus.in_req_pd));
      chk("rsp_rdy", 64'(bus.rsp_rdy), 64'(1));
      chk("rd_vld", 64'(bus.rd_vld), 64'(m_q.size() != 0));
      if (m_q.size() != 0) chk("rd_pd", 64'(bus.rd_pd), 64'(m_q[0]));
      chk("credits", 64'(credits), 64'(m_cred));
      chk("cdt_pop", 64'(cdt_pop), 64'(m_cdt));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else if (m_init) begin
      m_cred = m_cred - (grant ? need : 0) + int'(pop);
      if (grant) m_out += need;
      if (bus.rsp_vld && m_out > 0) m_out--;
      if (op_load) m_stall = '0;
      else if (perf_en && bus.in_req_vld && !ok && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (drop) m_ovf = 1'b1;
      else if (op_load) m_ovf = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (bus.rsp_vld && !drop) m_q.push_back(bus.rsp_pd);
      m_cdt = pop;
    end
  endtask

  task automatic deliver_drain(input int n);
    bus.rsp_vld = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.rsp_pd = $urandom;
      cycle();
    end
    bus.rsp_vld = 1'b0;
    bus.rd_rdy  = 1'b1;
    repeat (DEPTH + 2) cycle();
    bus.rd_rdy  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; op_load = 1'b0; perf_en = 1'b0;
    bus.in_req_vld = 1'b0; bus.in_req_pd = '0; bus.in_req_len = '0;
    bus.out_req_rdy = 1'b1; bus.rsp_vld = 1'b0; bus.rsp_pd = '0; bus.rd_rdy = 1'b0;
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    chk("rst_credits", 64'(credits), 64'(8));
    chk("rst_rd_vld", 64'(bus.rd_vld), 64'(0));
    chk("rst_stall", 64'(stall_cnt), 64'(0));
    chk("rst_ovf", 64'(ovf_err), 64'(0));

    // Single-beat loop
    bus.in_req_vld = 1'b1; bus.in_req_len = 4'd0; bus.in_req_pd = 16'h1234;
    cycle();
    bus.in_req_vld = 1'b0;
    chk("single_cred", 64'(credits), 64'(7));
    bus.rsp_vld = 1'b1; bus.rsp_pd = 32'hA5;
    cycle();
    bus.rsp_vld = 1'b0;
    chk("single_rd_vld", 64'(bus.rd_vld), 64'(1));
    chk("single_rd_pd", 64'(bus.rd_pd), 64'(32'hA5));
    bus.rd_rdy = 1'b1;
    cycle();
    bus.rd_rdy = 1'b0;
    chk("single_cred_back", 64'(credits), 64'(8));
    chk("single_cdt_pop", 64'(cdt_pop), 64'(1));
    cycle();
    chk("single_cdt_low", 64'(cdt_pop), 64'(0));

    // Credit exhaustion and stall counting
    bus.in_req_vld = 1'b1; bus.in_req_len = 4'd3;
    cycle(); cycle();
    chk("exh_cred0", 64'(credits), 64'(0));
    perf_en = 1'b1;
    repeat (5) cycle();
    chk("exh_stall5", 64'(stall_cnt), 64'(5));
    chk("exh_blk_rdy", 64'(bus.in_req_rdy), 64'(0));
    chk("exh_blk_vld", 64'(bus.out_req_vld), 64'(0));
    bus.rsp_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rsp_pd = 32'(i + 16);
      cycle();
    end
    bus.rsp_vld = 1'b0;
    bus.rd_rdy = 1'b1;
    repeat (4) cycle();
    bus.rd_rdy = 1'b0;
    chk("exh_cred4", 64'(credits), 64'(4));
    chk("exh_unblk", 64'(bus.in_req_rdy), 64'(1));
    cycle();
    bus.in_req_vld = 1'b0; perf_en = 1'b0;
    chk("exh_regrant", 64'(credits), 64'(0));
    chk("exh_stall13", 64'(stall_cnt), 64'(13));
    deliver_drain(8);
    chk("exh_restore", 64'(credits), 64'(8));

    // Pop returns a credit that is only usable the next cycle
    bus.in_req_vld = 1'b1; bus.in_req_len = 4'd6;
    cycle();
    bus.in_req_vld = 1'b0;
    chk("sim_cred1", 64'(credits), 64'(1));
    bus.rsp_vld = 1'b1;
    repeat (7) begin
      bus.rsp_pd = $urandom;
      cycle();
    end
    bus.rsp_vld = 1'b0;
    bus.in_req_vld = 1'b1; bus.in_req_len = 4'd1; bus.rd_rdy = 1'b1;
    chk("sim_no_grant", 64'(bus.in_req_rdy), 64'(0));
    cycle();
    bus.rd_rdy = 1'b0;
    chk("sim_cred2", 64'(credits), 64'(2));
    cycle();
    bus.in_req_vld = 1'b0;
    chk("sim_cred0", 64'(credits), 64'(0));
    deliver_drain(2);
    chk("sim_restore", 64'(credits), 64'(8));

    // Overflow: nine beats into eight slots
    bus.in_req_vld = 1'b1; bus.in_req_len = 4'd7;
    cycle();
    bus.in_req_vld = 1'b0;
    bus.rsp_vld = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.rsp_pd = 32'(100 + i);
      cycle();
    end
    bus.rsp_vld = 1'b0;
    chk("ovf_set", 64'(ovf_err), 64'(1));
    bus.rd_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("ovf_order", 64'(bus.rd_pd), 64'(100 + i));
      cycle();
    end
    bus.rd_rdy = 1'b0;
    chk("ovf_empty", 64'(bus.rd_vld), 64'(0));
    chk("ovf_cred", 64'(credits), 64'(8));
    op_load = 1'b1;
    cycle();
    op_load = 1'b0;
    chk("opl_ovf", 64'(ovf_err), 64'(0));
    chk("opl_stall", 64'(stall_cnt), 64'(0));

    // Random traffic across many pointer wraps
    for (int c = 0; c < 400; c++) begin
      bus.in_req_vld  = 1'($urandom_range(0, 1));
      bus.in_req_len  = 4'($urandom_range(0, 3));
      bus.in_req_pd   = 16'($urandom);
      bus.out_req_rdy = $urandom_range(0, 3) != 0;
      perf_en         = 1'($urandom_range(0, 1));
      op_load         = $urandom_range(0, 49) == 0;
      bus.rsp_vld     = (m_out > 0) && ($urandom_range(0, 2) != 0);
      bus.rsp_pd      = $urandom;
      bus.rd_rdy      = $urandom_range(0, 2) != 0;
      cycle();
    end
    bus.in_req_vld = 1'b0; bus.out_req_rdy = 1'b1; perf_en = 1'b0; op_load = 1'b0;
    bus.rd_rdy = 1'b1;
    for (int c = 0; c < 200 && (m_out > 0 || m_q.size() != 0); c++) begin
      bus.rsp_vld = m_out > 0;
      bus.rsp_pd  = $urandom;
      cycle();
    end
    bus.rsp_vld = 1'b0; bus.rd_rdy = 1'b0;
    cycle();
    chk("rand_restore", 64'(credits), 64'(8));
    chk("rand_empty", 64'(bus.rd_vld), 64'(0));

    // Reset mid-operation drops buffered beats and outstanding credits
    bus.in_req_vld = 1'b1; bus.in_req_len = 4'd3;
    cycle();
    bus.in_req_vld = 1'b0; bus.rsp_vld = 1'b1;
    cycle(); cycle();
    bus.rsp_vld = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("mid_rst_cred", 64'(credits), 64'(8));
    chk("mid_rst_rd_vld", 64'(bus.rd_vld), 64'(0));

    // Saturation with an oversized request that can never be granted
    bus.in_req_vld = 1'b1; bus.in_req_len = 4'd15; perf_en = 1'b1;
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    m_stall = 32'hFFFF_FFFD;
    repeat (5) cycle();
    chk("sat_hold", 64'(stall_cnt), 64'(32'hFFFF_FFFF));
    chk("sat_no_grant", 64'(bus.out_req_vld), 64'(0));
    chk("sat_cred", 64'(credits), 64'(8));
    op_load = 1'b1;
    cycle();
    op_load = 1'b0; bus.in_req_vld = 1'b0; perf_en = 1'b0;
    chk("sat_clear", 64'(stall_cnt), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sdp_rdma_lat_credit_fifo.md
Name: sdp_rdma_lat_credit_fifo

Overview:
Parametrised latency-FIFO-plus-credit controller for the SDP read DMAs (MRDMA/BRDMA/NRDMA/ERDMA). It gates outgoing DMA read requests so that every response beat has a guaranteed slot in an internal latency FIFO. It buffers response beats for the egress stage and emits a credit-pop pulse per beat consumed. It generalises the fixed per-engine latency FIFO with a configurable depth, data width and multi-beat request length, and adds stall counting and an overflow detector.

Parameters:
DEPTH, 64, latency FIFO entries (power of 2, >=4)
DATA_W, 514, response payload width
REQ_W, 79, request payload width
LEN_W, 4, request length field width (beats-1)
CNT_W, $clog2(DEPTH+1), credit counter width (derived)

Ports:
nvdla_core_clk  in  1  clock
nvdla_core_rst  in  1  synchronous active-high reset
op_load  in  1  layer start pulse; clears stall_cnt and ovf_err
perf_en  in  1  enables stall counting
in_req_vld  in  1  request valid from ig
in_req_rdy  out  1  request ready to ig
in_req_pd  in  REQ_W  request payload
in_req_len  in  LEN_W  beats-1 for this request
out_req_vld  out  1  request valid to dmaif
out_req_rdy  in  1  request ready from dmaif
out_req_pd  out  REQ_W  = in_req_pd
rsp_vld  in  1  response beat valid from dmaif
rsp_rdy  out  1  constant 1
rsp_pd  in  DATA_W  response beat
rd_vld  out  1  FIFO head valid to eg
rd_rdy  in  1  eg accepts head
rd_pd  out  DATA_W  FIFO head data
cdt_pop  out  1  one-cycle pulse per beat popped
credits  out  CNT_W  free credits
stall_cnt  out  32  request-blocked-by-credit cycles
ovf_err  out  1  sticky: beat arrived while FIFO full

Behaviour:
- Reset values: credits=DEPTH; FIFO empty; rd_vld=0; cdt_pop=0; stall_cnt=0; ovf_err=0. Reset mid-operation discards all FIFO contents and outstanding accounting.
- need = in_req_len+1, zero-extended to CNT_W. credit_ok = (credits >= need).
- Request path is combinational, with no added latency. out_req_vld = in_req_vld & credit_ok. in_req_rdy = out_req_rdy & credit_ok. out_req_pd = in_req_pd.
- A grant occurs when in_req_vld & in_req_rdy.
- Credit update each cycle: credits_next = credits - (grant ? need : 0) + (pop ? 1 : 0), where pop = rd_vld & rd_rdy. Grant and pop in the same cycle apply net. A credit returned at cycle t is usable at t+1. credits never exceeds DEPTH and never underflows.
- If need > DEPTH, the request never grants. It stalls indefinitely and is counted as a stall; it is the requester's obligation never to issue it.
- FIFO write: rsp_vld with FIFO not full writes the beat. The beat is visible on rd_pd with rd_vld=1 the next cycle (1-cycle write-to-read latency).
- FIFO write while full: the beat is dropped, ovf_err is set, and the FIFO state is unchanged.
- Simultaneous write and pop when full: the pop frees the slot first, so the write succeeds and ovf_err is not set.
- Read: rd_pd holds stable while rd_vld & !rd_rdy. cdt_pop is registered: it equals pop delayed by 1 cycle.
- Pointers: log2(DEPTH)-bit pointers wrap modulo DEPTH. Full/empty is taken from an occupancy count of width CNT_W.
- stall_cnt increments when perf_en & in_req_vld & !credit_ok. It saturates at 0xFFFFFFFF. op_load clears it to 0, and op_load has priority over increment in the same cycle.
- ovf_err is cleared by op_load or reset; set has priority over an op_load clear in the same cycle.
- op_load does not alter credits or the FIFO; in-flight traffic of the previous layer drains normally.

Test Plan:
- Reset, then DEPTH=8: credits=8, rd_vld=0, stall_cnt=0, ovf_err=0; rsp_rdy=1 throughout.
- Single-beat loop: out_req_rdy=1, one request len=0 -> credits=7. Response beat D=0xA5 -> rd_vld=1 next cycle with rd_pd=0xA5. rd_rdy=1 -> credits=8 one cycle later and cdt_pop pulses one cycle after the pop.
- Credit exhaustion: two len=3 requests -> credits=0. Third request stays blocked (in_req_rdy=0, out_req_vld=0) with perf_en=1, stall_cnt +1 per cycle. Pop 4 beats -> request grants the cycle after credits reach 4.
- Simultaneous grant and pop at credits=1, len=1 request, one pop: no grant that cycle; next cycle credits=2 -> grant -> credits=0.
- Overflow: force 9 beats with no pops into a full DEPTH=8 FIFO -> 9th beat dropped, ovf_err=1, 8 beats read back in order. op_load -> ovf_err=0 and stall_cnt=0.
- Wrap and saturation: stream 3*DEPTH beats with random rd_rdy -> data order preserved across pointer wrap. Preload stall_cnt near 0xFFFFFFFF via long stall -> holds at max.
